// File: rtl/timed_parade_traffic_light.sv
// Two-street traffic light with min/max green timing, timed yellow, all-red
// clearance and a parade mode that parks the intersection on street B green.
module timed_parade_traffic_light #(
  parameter int unsigned MIN_GREEN     = 4,
  parameter int unsigned MAX_GREEN     = 12,
  parameter int unsigned YELLOW_CYCLES = 2,
  parameter int unsigned ALLRED_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       P,
  input  logic       R,
  output logic [2:0] La,
  output logic [2:0] Lb,
  output logic [2:0] States_light_out,
  output logic       M
);

  localparam int unsigned TMAX_A = (MAX_GREEN > YELLOW_CYCLES) ? MAX_GREEN : YELLOW_CYCLES;
  localparam int unsigned TMAX   = (TMAX_A > ALLRED_CYCLES) ? TMAX_A : ALLRED_CYCLES;
  localparam int unsigned TW     = $clog2(TMAX) + 1;

  localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_LAST = TW'(YELLOW_CYCLES - 1);
  localparam logic [TW-1:0] CLR_LAST = TW'(ALLRED_CYCLES - 1);

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  typedef enum logic [2:0] {
    S_AG   = 3'd0,
    S_AY   = 3'd1,
    S_ACLR = 3'd2,
    S_BG   = 3'd3,
    S_BY   = 3'd4,
    S_BCLR = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          m_q, m_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_AG;
      timer_q <= '0;
      m_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      m_q     <= m_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_AG: begin
        if (timer_q >= MIN_LAST && (!Ta || m_q || (Tb && timer_q >= MAX_LAST)))
          state_d = S_AY;
      end
      S_AY:   if (timer_q == YEL_LAST) state_d = S_ACLR;
      S_ACLR: if (timer_q == CLR_LAST) state_d = S_BG;
      S_BG: begin
        // Parade mode parks B green; max-green yielding is suspended while M is set.
        if (timer_q >= MIN_LAST && !m_q && (!Tb || (Ta && timer_q >= MAX_LAST)))
          state_d = S_BY;
      end
      S_BY:   if (timer_q == YEL_LAST) state_d = S_BCLR;
      S_BCLR: if (timer_q == CLR_LAST) state_d = S_AG;
      default: state_d = S_AG;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_comb begin
    m_d = m_q;
    if (P && !R) begin
      m_d = 1'b1;
    end else if (R && !P) begin
      m_d = 1'b0;
    end
  end

  always_comb begin
    La = LAMP_R;
    Lb = LAMP_R;
    case (state_q)
      S_AG:    La = LAMP_G;
      S_AY:    La = LAMP_Y;
      S_BG:    Lb = LAMP_G;
      S_BY:    Lb = LAMP_Y;
      default: ;
    endcase
  end

  assign States_light_out = state_q;
  assign M                = m_q;

endmodule

// File: tb/tb_timed_parade_traffic_light.sv
// Bench for timed_parade_traffic_light: vector table, directed corner sequences
// and random stimulus against an elapsed-cycle reference model.
module tb_timed_parade_traffic_light;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Ta = 1'b0, Tb = 1'b0, P = 1'b0, R = 1'b0;
  logic [2:0] La1, Lb1, st1, La2, Lb2, st2;
  logic       M1, M2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  timed_parade_traffic_light #(
    .MIN_GREEN(4), .MAX_GREEN(12), .YELLOW_CYCLES(2), .ALLRED_CYCLES(1)
  ) dut (
    .clk(clk), .rst(rst), .Ta(Ta), .Tb(Tb), .P(P), .R(R),
    .La(La1), .Lb(Lb1), .States_light_out(st1), .M(M1)
  );

  timed_parade_traffic_light #(
    .MIN_GREEN(1), .MAX_GREEN(1), .YELLOW_CYCLES(1), .ALLRED_CYCLES(1)
  ) dut_fast (
    .clk(clk), .rst(rst), .Ta(Ta), .Tb(Tb), .P(P), .R(R),
    .La(La2), .Lb(Lb2), .States_light_out(st2), .M(M2)
  );

  // Reference model: phase index 0..5 and number of cycles spent in it so far.
  typedef struct {
    int ph;
    int cnt;
    bit m;
  } mdl_t;

  mdl_t m1, m2;

  function automatic mdl_t mstep(mdl_t s, bit r_st, bit ta, bit tb, bit p, bit r,
                                 int ming, int maxg, int yel, int clr);
    mdl_t n;
    bit   ex;
    if (r_st) begin
      n.ph = 0; n.cnt = 1; n.m = 1'b0;
      return n;
    end
    ex = 1'b0;
    case (s.ph)
      0:       ex = (s.cnt >= ming) && (!ta || s.m || (tb && s.cnt >= maxg));
      1, 4:    ex = (s.cnt >= yel);
      2, 5:    ex = (s.cnt >= clr);
      3:       ex = (s.cnt >= ming) && !s.m && (!tb || (ta && s.cnt >= maxg));
      default: ex = 1'b1;
    endcase
    n.ph  = ex ? (s.ph + 1) % 6 : s.ph;
    n.cnt = ex ? 1 : ((s.cnt < 1000000) ? s.cnt + 1 : s.cnt);
    n.m   = (p && !r) ? 1'b1 : ((r && !p) ? 1'b0 : s.m);
    return n;
  endfunction

  function automatic logic [2:0] lamp_a(int ph);
    return (ph == 0) ? 3'b001 : ((ph == 1) ? 3'b010 : 3'b100);
  endfunction

  function automatic logic [2:0] lamp_b(int ph);
    return (ph == 3) ? 3'b001 : ((ph == 4) ? 3'b010 : 3'b100);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample DUT after the edge and compare both instances to the model.
  task automatic tick();
    @(posedge clk);
    #1;
    m1 = mstep(m1, rst, Ta, Tb, P, R, 4, 12, 2, 1);
    m2 = mstep(m2, rst, Ta, Tb, P, R, 1, 1, 1, 1);
    chk("mdl_state", int'(st1), m1.ph);
    chk("mdl_La",    int'(La1), int'(lamp_a(m1.ph)));
    chk("mdl_Lb",    int'(Lb1), int'(lamp_b(m1.ph)));
    chk("mdl_M",     int'(M1),  int'(m1.m));
    chk("mdl_fast_state", int'(st2), m2.ph);
    chk("mdl_fast_La",    int'(La2), int'(lamp_a(m2.ph)));
    chk("mdl_fast_Lb",    int'(Lb2), int'(lamp_b(m2.ph)));
    chk("safety", int'((La1 != 3'b100) && (Lb1 != 3'b100)), 0);
    chk("safety_fast", int'((La2 != 3'b100) && (Lb2 != 3'b100)), 0);
  endtask

  task automatic set_in(input bit r_st, input bit ta, input bit tb, input bit p, input bit r);
    rst = r_st; Ta = ta; Tb = tb; P = p; R = r;
  endtask

  typedef struct {
    bit         rst, ta, tb, p, r;
    logic [2:0] st, la, lb;
    bit         m;
  } vec_t;

  vec_t vecs[20];
  int   hist[70];
  bit   found;

  initial begin
    // Basic A->B->A walk: reset, idle streets, then B traffic holds B green.
    vecs[0] = '{1, 0, 0, 0, 0, 3'd0, 3'b001, 3'b100, 0};
    for (int i = 1; i <= 3; i++) vecs[i] = '{0, 0, 0, 0, 0, 3'd0, 3'b001, 3'b100, 0};
    vecs[4] = '{0, 0, 0, 0, 0, 3'd1, 3'b010, 3'b100, 0};
    vecs[5] = '{0, 0, 0, 0, 0, 3'd1, 3'b010, 3'b100, 0};
    vecs[6] = '{0, 0, 0, 0, 0, 3'd2, 3'b100, 3'b100, 0};
    vecs[7] = '{0, 0, 0, 0, 0, 3'd3, 3'b100, 3'b001, 0};
    for (int i = 8; i <= 14; i++) vecs[i] = '{0, 0, 1, 0, 0, 3'd3, 3'b100, 3'b001, 0};
    vecs[15] = '{0, 1, 0, 0, 0, 3'd4, 3'b100, 3'b010, 0};
    vecs[16] = '{0, 1, 0, 0, 0, 3'd4, 3'b100, 3'b010, 0};
    vecs[17] = '{0, 1, 0, 0, 0, 3'd5, 3'b100, 3'b100, 0};
    vecs[18] = '{0, 1, 0, 0, 0, 3'd0, 3'b001, 3'b100, 0};
    vecs[19] = '{0, 1, 0, 0, 0, 3'd0, 3'b001, 3'b100, 0};

    for (int i = 0; i < 20; i++) begin
      set_in(vecs[i].rst, vecs[i].ta, vecs[i].tb, vecs[i].p, vecs[i].r);
      tick();
      chk("vec_state", int'(st1), int'(vecs[i].st));
      chk("vec_La", int'(La1), int'(vecs[i].la));
      chk("vec_Lb", int'(Lb1), int'(vecs[i].lb));
      chk("vec_M", int'(M1), int'(vecs[i].m));
    end

    // A traffic only: A stays green, no max-green exit.
    set_in(1, 1, 0, 0, 0); tick(); tick();
    set_in(0, 1, 0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("a_only_state", int'(st1), 0);
      chk("a_only_La", int'(La1), 1);
      chk("a_only_Lb", int'(Lb1), 4);
      chk("a_only_M", int'(M1), 0);
    end

    // Both streets busy: 12-cycle greens, period 30.
    set_in(1, 1, 1, 0, 0); tick();
    hist[0] = int'(st1);
    set_in(0, 1, 1, 0, 0);
    for (int i = 1; i < 70; i++) begin
      tick();
      hist[i] = int'(st1);
    end
    chk("maxg_ag_last", hist[11], 0);
    chk("maxg_ay_first", hist[12], 1);
    chk("maxg_aclr", hist[14], 2);
    chk("maxg_bg_first", hist[15], 3);
    chk("maxg_bg_last", hist[26], 3);
    chk("maxg_by_first", hist[27], 4);
    chk("maxg_bclr", hist[29], 5);
    chk("maxg_ag_again", hist[30], 0);
    chk("maxg_period", hist[42], 1);

    // Parade: P pulse in AG, forced handover, B held, release yields.
    set_in(1, 1, 0, 0, 0); tick();
    set_in(0, 1, 0, 1, 0); tick();
    chk("parade_set_M", int'(M1), 1);
    chk("parade_set_state", int'(st1), 0);
    set_in(0, 1, 0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (st1 == 3'd3) found = 1'b1;
    end
    chk("parade_reach_bg", int'(found), 1);
    set_in(0, 1, 1, 0, 0);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("parade_hold_bg", int'(st1), 3);
    end
    set_in(0, 1, 1, 0, 1); tick();
    chk("release_M", int'(M1), 0);
    chk("release_still_bg", int'(st1), 3);
    set_in(0, 1, 1, 0, 0); tick();
    chk("release_by", int'(st1), 4);

    // P and R together leave M alone.
    set_in(0, 1, 1, 1, 1); tick();
    chk("pr_both_m0", int'(M1), 0);
    set_in(0, 1, 1, 1, 0); tick();
    chk("p_sets_m", int'(M1), 1);
    set_in(0, 1, 1, 1, 1); tick();
    chk("pr_both_m1", int'(M1), 1);
    set_in(0, 1, 1, 0, 1); tick();

    // Reset in S_BY, then minimum green re-enforced.
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (st1 == 3'd4) found = 1'b1;
    end
    chk("reach_by", int'(found), 1);
    set_in(0, 0, 0, 1, 0); tick();
    chk("by_m_set", int'(M1), 1);
    set_in(1, 0, 0, 0, 0); tick();
    chk("rst_by_state", int'(st1), 0);
    chk("rst_by_La", int'(La1), 1);
    chk("rst_by_M", int'(M1), 0);
    set_in(0, 0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("rst_min_green", int'(st1), 0);
    end
    tick();
    chk("rst_min_green_exit", int'(st1), 1);

    // All-ones parameter instance: one cycle per state.
    set_in(1, 1, 1, 0, 0); tick();
    chk("fast_reset", int'(st2), 0);
    set_in(0, 1, 1, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("fast_seq", int'(st2), i % 6);
    end

    // Random traffic, parade requests and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      set_in(($urandom_range(99) == 0), 1'($urandom), 1'($urandom),
             ($urandom_range(15) == 0), ($urandom_range(15) == 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
